// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg_pkg
//  Description : Shared constants and types for the P7 inter-stage pipeline
//                register. Every stage instance draws its reset/handler PCs
//                and the "no exception" encoding from here.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_reg_pkg;

    // Exception code meaning "nothing pending"
    localparam logic [31:0] c_EXC_NONE   = 32'd0;
    // PC presented after reset
    localparam logic [31:0] c_RESET_PC   = 32'h0000_3000;
    // Exception handler entry point
    localparam logic [31:0] c_HANDLER_PC = 32'h0000_4180;

    // The single action applied on a clock edge (reset handled separately)
    typedef enum logic [2:0] {
        ACT_REQ    = 3'd0,
        ACT_ERET   = 3'd1,
        ACT_HOLD   = 3'd2,
        ACT_BUBBLE = 3'd3,
        ACT_LOAD   = 3'd4
    } stage_act_e;

    // Priority decode of the control inputs: req > eret > hold > bubble > load
    function automatic stage_act_e decode_act(
        input logic req,
        input logic eret,
        input logic hold,
        input logic bubble
    );
        if (req)         return ACT_REQ;
        else if (eret)   return ACT_ERET;
        else if (hold)   return ACT_HOLD;
        else if (bubble) return ACT_BUBBLE;
        else             return ACT_LOAD;
    endfunction

endpackage : pipe_stage_reg_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg_exc_merge.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg_exc_merge
//  Description : Combinational exception merge. The older (upstream) code
//                wins over the one detected locally; an invalid slot never
//                carries an exception.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg_exc_merge #(
    parameter int              EXC_W    = 5,
    parameter logic [EXC_W-1:0] EXC_NONE = '0
) (
    input  logic             i_valid,
    input  logic [EXC_W-1:0] i_exc,
    input  logic [EXC_W-1:0] i_local_exc,
    output logic [EXC_W-1:0] o_exc
);

    // Valid-gated first-exception-wins select
    always_comb begin
        o_exc = EXC_NONE;
        if (i_valid) begin
            if (i_exc != EXC_NONE) o_exc = i_exc;
            else                   o_exc = i_local_exc;
        end
    end

endmodule : pipe_stage_reg_exc_merge
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Parametrised inter-stage pipeline register (IF/ID, ID/EX,
//                EX/MEM, MEM/WB) with hold, bubble, exception flush, eret
//                redirect, exception merge and a saturating bubble counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int               DATA_W     = 96,
    parameter int               EXC_W      = 5,
    parameter logic [EXC_W-1:0] EXC_NONE   = EXC_W'(c_EXC_NONE),
    parameter logic [31:0]      RESET_PC   = c_RESET_PC,
    parameter logic [31:0]      HANDLER_PC = c_HANDLER_PC,
    parameter int               CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              eret,
    input  logic              hold,
    input  logic              bubble,
    input  logic [31:0]       in_epc,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_is_delay,
    input  logic              in_valid,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic [EXC_W-1:0]  in_local_exc,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic              out_is_delay,
    output logic              out_valid,
    output logic [EXC_W-1:0]  out_exc,
    output logic [CNT_W-1:0]  bubble_cnt
);

    stage_act_e        w_act;
    logic [EXC_W-1:0]  w_merged_exc;

    logic [31:0]       r_pc_q,       w_pc_d;
    logic [DATA_W-1:0] r_data_q,     w_data_d;
    logic              r_is_delay_q, w_is_delay_d;
    logic              r_valid_q,    w_valid_d;
    logic [EXC_W-1:0]  r_exc_q,      w_exc_d;
    logic [CNT_W-1:0]  r_cnt_q,      w_cnt_d;

    pipe_stage_reg_exc_merge #(
        .EXC_W    (EXC_W),
        .EXC_NONE (EXC_NONE)
    ) u_exc_merge (
        .i_valid     (in_valid),
        .i_exc       (in_exc),
        .i_local_exc (in_local_exc),
        .o_exc       (w_merged_exc)
    );

    // Next-state selection: one action per edge, default is to keep contents
    always_comb begin
        w_act        = decode_act(req, eret, hold, bubble);
        w_pc_d       = r_pc_q;
        w_data_d     = r_data_q;
        w_is_delay_d = r_is_delay_q;
        w_valid_d    = r_valid_q;
        w_exc_d      = r_exc_q;
        w_cnt_d      = r_cnt_q;
        case (w_act)
            ACT_REQ: begin
                w_pc_d       = HANDLER_PC;
                w_data_d     = '0;
                w_is_delay_d = 1'b0;
                w_valid_d    = 1'b0;
                w_exc_d      = EXC_NONE;
            end
            ACT_ERET: begin
                w_pc_d       = in_epc;
                w_data_d     = '0;
                w_is_delay_d = 1'b0;
                w_valid_d    = 1'b0;
                w_exc_d      = EXC_NONE;
            end
            ACT_HOLD: begin
                // Everything, including the counter, stays put
            end
            ACT_BUBBLE: begin
                // PC and BD bit survive so an interrupt can still form EPC
                w_pc_d       = in_pc;
                w_is_delay_d = in_is_delay;
                w_data_d     = '0;
                w_valid_d    = 1'b0;
                w_exc_d      = EXC_NONE;
                if (r_cnt_q != {CNT_W{1'b1}}) w_cnt_d = r_cnt_q + 1'b1;
            end
            default: begin
                w_pc_d       = in_pc;
                w_data_d     = in_data;
                w_is_delay_d = in_is_delay;
                w_valid_d    = in_valid;
                w_exc_d      = w_merged_exc;
            end
        endcase
    end

    // Stage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_q       <= RESET_PC;
            r_data_q     <= '0;
            r_is_delay_q <= 1'b0;
            r_valid_q    <= 1'b0;
            r_exc_q      <= EXC_NONE;
            r_cnt_q      <= '0;
        end else begin
            r_pc_q       <= w_pc_d;
            r_data_q     <= w_data_d;
            r_is_delay_q <= w_is_delay_d;
            r_valid_q    <= w_valid_d;
            r_exc_q      <= w_exc_d;
            r_cnt_q      <= w_cnt_d;
        end
    end

    assign out_pc       = r_pc_q;
    assign out_data     = r_data_q;
    assign out_is_delay = r_is_delay_q;
    assign out_valid    = r_valid_q;
    assign out_exc      = r_exc_q;
    assign bubble_cnt   = r_cnt_q;

endmodule : pipe_stage_reg
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the P7 five-stage MIPS core. It generalises the existing per-stage latch: one instance serves IF/ID, ID/EX, EX/MEM or MEM/WB, selected by payload width.
- Carries PC, an opaque payload bus, delay-slot flag, exception code and a valid bit.
- Adds hold (freeze), bubble, exception flush, eret redirect, first-exception-wins merge and a bubble-cycle performance counter.

Parameters:
DATA_W, 96, width of the opaque payload (instruction, operands, immediates, ...)
EXC_W, 5, exception code width
EXC_NONE, 0, encoding of "no exception"
RESET_PC, 32'h0000_3000, PC loaded on reset
HANDLER_PC, 32'h0000_4180, PC loaded on exception request
CNT_W, 16, width of bubble counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
req  in  1  exception request: flush stage, redirect to HANDLER_PC
eret  in  1  eret redirect: flush stage, load in_epc as PC
hold  in  1  freeze stage contents (downstream stall)
bubble  in  1  insert bubble (upstream stall / hazard)
in_epc  in  32  eret target PC
in_pc  in  32  upstream PC
in_data  in  DATA_W  upstream payload
in_is_delay  in  1  upstream delay-slot flag
in_valid  in  1  upstream valid
in_exc  in  EXC_W  exception code already carried by upstream
in_local_exc  in  EXC_W  exception detected in the producing stage
out_pc  out  32  registered PC
out_data  out  DATA_W  registered payload
out_is_delay  out  1  registered delay-slot flag
out_valid  out  1  registered valid
out_exc  out  EXC_W  registered merged exception code
bubble_cnt  out  CNT_W  count of bubble cycles since reset

Behaviour:
- All outputs are registered. Latency from input to output is 1 cycle. There is no combinational path from inputs to outputs.
- Reset values: out_pc=RESET_PC, out_data=0, out_is_delay=0, out_valid=0, out_exc=EXC_NONE, bubble_cnt=0.
- Each rising edge applies exactly one action. Priority order is reset > req > eret > hold > bubble > load.
- req: out_pc=HANDLER_PC, out_data=0, out_is_delay=0, out_valid=0, out_exc=EXC_NONE.
- eret (req=0): out_pc=in_epc, out_data=0, out_is_delay=0, out_valid=0, out_exc=EXC_NONE.
- hold: every register keeps its value, including out_valid and out_exc. bubble_cnt does not increment.
- bubble (hold=0):
  - out_pc=in_pc and out_is_delay=in_is_delay, so the macro-PC and BD bit remain valid for interrupt EPC.
  - out_data=0, out_valid=0, out_exc=EXC_NONE.
  - bubble_cnt increments by 1.
- load: out_pc=in_pc, out_data=in_data, out_is_delay=in_is_delay, out_valid=in_valid.
  - out_exc = in_exc when in_exc≠EXC_NONE; otherwise in_local_exc. The upstream (older) exception wins.
- If in_valid=0 on load, out_exc is forced to EXC_NONE. An invalid slot never raises an exception.
- bubble_cnt saturates at all-ones; it does not wrap. It is cleared only by reset.
- Simultaneous events:
  - req+eret: req wins.
  - hold+bubble: hold wins and no count is taken.
  - req during hold: flush takes effect in the same edge.
- Reset asserted mid-stream overrides everything in that cycle. The first post-reset load behaves normally.

Decomposition:
- Shared package/define file holds EXC_NONE, RESET_PC and HANDLER_PC (alongside the existing `None` / opcode defines) so every stage instance uses one source.
- One natural sub-module, exc_merge: combinational priority select of in_exc / in_local_exc / valid-gating, reused by the exception unit.
- The counter stays inline.

Test Plan:
1. Reset then load: reset=1 for 1 cycle → out_pc=0x3000, out_valid=0, bubble_cnt=0. Then in_pc=0x3004, in_data=0xABC, in_valid=1, no controls → next cycle out_pc=0x3004, out_data=0xABC, out_valid=1.
2. Hold vs bubble:
   - hold=1 for 3 cycles while inputs change → outputs frozen at prior values, bubble_cnt unchanged.
   - Then bubble=1 with in_pc=0x3010, in_is_delay=1 → out_pc=0x3010, out_is_delay=1, out_data=0, out_valid=0, bubble_cnt=1.
3. Exception merge:
   - in_exc=4, in_local_exc=12, in_valid=1 → out_exc=4.
   - in_exc=EXC_NONE, in_local_exc=12 → out_exc=12.
   - in_valid=0, in_local_exc=12 → out_exc=EXC_NONE.
4. Flush priority: req=1, eret=1, hold=1, bubble=1 together → out_pc=0x4180, all other fields cleared, bubble_cnt unchanged.
5. Eret: eret=1, in_epc=0x3020, hold=1 → out_pc=0x3020, out_valid=0, out_exc=EXC_NONE.
6. Counter saturation (CNT_W=4): 20 consecutive bubble cycles → bubble_cnt=15. Then reset → bubble_cnt=0.
